// File: rtl/sr_pulse_ctrl.sv
// Debounced set/reset requests -> single-cycle S/R pulses for the SR flip-flop stage; S and R are never high together.
// Define SR_PULSE_CTRL_SYNC_EN to add a 2-FF synchroniser on each raw input (+2 cycles latency).
module sr_pulse_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic reset_in,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE   = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  // Index 0 carries the set request, index 1 the reset request.
  logic [1:0]    smp;
  logic [1:0]    deb_lvl;
  logic [1:0]    rise;
  logic [CW-1:0] cnt [2];
  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          set_pend;
  logic          reset_pend;
  logic          take_set;
  logic          take_reset;

`ifdef SR_PULSE_CTRL_SYNC_EN
  logic [1:0] set_sync;
  logic [1:0] reset_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      set_sync   <= 2'b00;
      reset_sync <= 2'b00;
    end else begin
      set_sync   <= {set_sync[0], set_in};
      reset_sync <= {reset_sync[0], reset_in};
    end
  end

  assign smp = {reset_sync[1], set_sync[1]};
`else
  assign smp = {reset_in, set_in};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (smp[i] == deb_lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb_lvl[i] <= smp[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A rise is flagged on the same edge the debounced level flips high.
  always_comb begin
    rise = 2'b00;
    for (int i = 0; i < 2; i++)
      rise[i] = smp[i] & ~deb_lvl[i] & (cnt[i] == CNT_LAST);
  end

  assign take_reset = (state == IDLE) & reset_pend;
  assign take_set   = (state == IDLE) & set_pend & ~reset_pend;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      S          <= 1'b0;
      R          <= 1'b0;
      conflict   <= 1'b0;
      set_pend   <= 1'b0;
      reset_pend <= 1'b0;
    end else begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
      // A new rise on the consuming edge counts as a fresh request.
      set_pend   <= rise[0] | (set_pend & ~take_set);
      reset_pend <= rise[1] | (reset_pend & ~take_reset);
      case (state)
        IDLE: begin
          if (reset_pend) begin
            R        <= 1'b1;
            conflict <= set_pend;
            state    <= PULSE;
          end else if (set_pend) begin
            S     <= 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (HOLDOFF_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            state    <= HOLDOFF;
            hold_cnt <= HOLD_LAST;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
